// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and mask helpers for the data-memory responder.
//   size_e  : access size encoding (byte/half/word/double)
//   state_e : responder FSM states
//   byte_mask / width_mask / align_mask : per-size lane masks
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // One bit per byte of the access, right-aligned.
  function automatic logic [7:0] byte_mask(input size_e size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      SZ_D:    return 8'hFF;
      default: return 8'hFF;
    endcase
  endfunction

  // One bit per data bit of the access, right-aligned.
  function automatic logic [63:0] width_mask(input size_e size);
    case (size)
      SZ_B:    return 64'h0000_0000_0000_00FF;
      SZ_H:    return 64'h0000_0000_0000_FFFF;
      SZ_W:    return 64'h0000_0000_FFFF_FFFF;
      SZ_D:    return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Low byte-offset bits that must be zero for natural alignment.
  function automatic logic [2:0] align_mask(input size_e size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      SZ_D:    return 3'b111;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// dmem_lane_merge: combinational lane logic for the data-memory responder.
//   old_word  in  : word being modified by a store
//   wdata     in  : store data, right-aligned
//   rd_word   in  : word being read by a load
//   offset    in  : byte offset inside the 64-bit word
//   size      in  : access size
//   new_word  out : old_word with the store lane replaced
//   load_data out : addressed lane of rd_word, right-aligned, zero-extended
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [63:0] old_word,
  input  logic [63:0] wdata,
  input  logic [63:0] rd_word,
  input  logic [2:0]  offset,
  input  size_e       size,
  output logic [63:0] new_word,
  output logic [63:0] load_data
);

  logic [5:0]  shift_s;
  logic [7:0]  lane_bytes_s;
  logic [63:0] bit_mask_s;
  logic [63:0] wmask_s;
  logic [63:0] wdata_sh_s;

  // Expand the shifted byte mask to bits, then merge and extract.
  always_comb begin
    shift_s      = {offset, 3'b000};
    wmask_s      = width_mask(size);
    lane_bytes_s = byte_mask(size) << offset;
    bit_mask_s   = 64'd0;
    for (int i = 0; i < 8; i++) begin
      bit_mask_s[8*i +: 8] = {8{lane_bytes_s[i]}};
    end
    wdata_sh_s = (wdata & wmask_s) << shift_s;
    new_word   = (old_word & ~bit_mask_s) | (wdata_sh_s & bit_mask_s);
    load_data  = (rd_word >> shift_s) & wmask_s;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: 64-bit-wide data memory behind a valid/ready
// request/response handshake, with LATENCY wait states before the array
// access and read-modify-write for sub-word stores.
//   clock, reset       : single clock, synchronous active-high reset
//   req_valid/req_ready: request handshake (ready only while idle)
//   req_we, req_size   : store flag and access size (0=B,1=H,2=W,3=D)
//   req_addr, req_wdata: byte address and right-aligned store data
//   resp_valid/ready   : response handshake
//   resp_rdata         : load lane, right-aligned, zero-extended (0 for stores)
//   resp_err           : misaligned-access flag
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// accesses are flagged and suppressed; otherwise the offset is force-aligned
// and resp_err is always 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW    = IDX_W + 3;
  // WAIT exits when the counter reaches zero, so load LATENCY-1.
  localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [63:0] mem [DEPTH];

  state_e      state_r;
  logic [3:0]  cnt_r;
  logic        we_r;
  size_e       size_r;
  logic [AW-1:0] addr_r;
  logic [63:0] wdata_r;
  logic        err_r;
  logic [63:0] old_word_r;
  logic        req_ready_r;
  logic        resp_valid_r;
  logic [63:0] resp_rdata_r;
  logic        resp_err_r;

  logic [IDX_W-1:0] idx_s;
  logic [63:0]      rd_word_s;
  logic [2:0]       offset_s;
  logic [63:0]      new_word_s;
  logic [63:0]      load_data_s;
  logic             misalign_s;
  size_e            size_in_s;

  // Upper address bits select nothing: the index wraps modulo DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[63:AW];

  assign size_in_s = size_e'(req_size);
  assign idx_s     = addr_r[AW-1:3];
  assign rd_word_s = mem[idx_s];

`ifdef DMEM_MISALIGN_TRAP_EN
  // Flag requests whose offset has any bit set below the access size.
  always_comb begin
    misalign_s = ((req_addr[2:0] & align_mask(size_in_s)) != 3'b000);
    offset_s   = addr_r[2:0];
  end
`else
  // No trapping: drop the low offset bits to force natural alignment.
  always_comb begin
    misalign_s = 1'b0;
    offset_s   = addr_r[2:0] & ~align_mask(size_r);
  end
`endif

  dmem_lane_merge u_lane_merge (
    .old_word  (old_word_r),
    .wdata     (wdata_r),
    .rd_word   (rd_word_s),
    .offset    (offset_s),
    .size      (size_r),
    .new_word  (new_word_s),
    .load_data (load_data_s)
  );

  // Array write; only WRITE stores, and never in a reset cycle.
  always_ff @(posedge clock) begin
    if (!reset && (state_r == ST_WRITE)) begin
      mem[idx_s] <= new_word_s;
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      we_r         <= 1'b0;
      size_r       <= SZ_B;
      addr_r       <= '0;
      wdata_r      <= 64'd0;
      err_r        <= 1'b0;
      old_word_r   <= 64'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 64'd0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            we_r        <= req_we;
            size_r      <= size_in_s;
            addr_r      <= req_addr[AW-1:0];
            wdata_r     <= req_wdata;
            err_r       <= misalign_s;
            req_ready_r <= 1'b0;
            if (LATENCY > 0) begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_LOAD;
            end else begin
              state_r <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= ST_ACCESS;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_ACCESS: begin
          old_word_r <= rd_word_s;
          if (!we_r || err_r) begin
            // Loads and flagged requests respond straight from the array read.
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= err_r;
            resp_rdata_r <= (we_r || err_r) ? 64'd0 : load_data_s;
          end else begin
            state_r <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          state_r      <= ST_RESP;
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 64'd0;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_r      <= ST_IDLE;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 64'd0;
            resp_err_r   <= 1'b0;
            req_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          cnt_r        <= 4'd0;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 64'd0;
          resp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder. A byte-level
// memory model computes expected load data, error flags and latencies.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [63:0] model_mem [DEPTH];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Byte-level reference: applies a store or returns the load lane.
  function automatic logic [63:0] model_access(input bit we, input logic [1:0] size,
                                               input logic [63:0] addr, input logic [63:0] wdata,
                                               output bit err);
    int nbytes = 1 << size;
    int off    = int'(addr[2:0]);
    int idx    = int'((addr >> 3) % DEPTH);
    logic [63:0] r = 64'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
    err = (off % nbytes) != 0;
`else
    err = 1'b0;
    off = off - (off % nbytes);
`endif
    if (err) return 64'd0;
    for (int b = 0; b < nbytes; b++) begin
      if (we) model_mem[idx][(off + b) * 8 +: 8] = wdata[b * 8 +: 8];
      else    r[b * 8 +: 8] = model_mem[idx][(off + b) * 8 +: 8];
    end
    return r;
  endfunction

  // Drive one request with resp_ready high; returns response and latency.
  task automatic do_req(input bit we, input logic [1:0] size, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata,
                        output logic err, output int lat, output int acc_cyc);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    @(posedge clock); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clock); #1; n++;
    end
    n_checks++;
    if (!resp_valid) begin
      n_fail++;
      $display("FAIL resp_timeout: resp_valid=%0b after %0d cycles, required 1", resp_valid, n);
    end
    lat   = n + 1;
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    n_checks += 4;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %0b, required 1", req_ready); end
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %0b, required 0", resp_valid); end
    if (resp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h, required 0", resp_rdata); end
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b, required 0", resp_err); end
  endtask

  task automatic test_load_basic;
    logic [63:0] rd, exp; logic er; bit eerr; int lat, acc;
    exp = model_access(1'b1, 2'd3, 64'h0, 64'h1122334455667788, eerr);
    do_req(1'b1, 2'd3, 64'h0, 64'h1122334455667788, rd, er, lat, acc);
    n_checks++;
    if (lat != LAT + 3) begin n_fail++; $display("FAIL store_latency: got %0d, required %0d", lat, LAT + 3); end
    exp = model_access(1'b0, 2'd0, 64'h3, 64'h0, eerr);
    do_req(1'b0, 2'd0, 64'h3, 64'h0, rd, er, lat, acc);
    n_checks += 3;
    if (lat != LAT + 2) begin n_fail++; $display("FAIL load_latency: got %0d, required %0d", lat, LAT + 2); end
    if (rd !== 64'h55 || exp !== 64'h55) begin n_fail++; $display("FAIL load_byte: got %h, required 55", rd); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL load_byte_err: got %0b, required 0", er); end
  endtask

  task automatic test_store_byte;
    logic [63:0] rd, exp; logic er; bit eerr; int lat, acc;
    exp = model_access(1'b1, 2'd0, 64'h5, 64'hAB, eerr);
    do_req(1'b1, 2'd0, 64'h5, 64'hAB, rd, er, lat, acc);
    n_checks += 2;
    if (lat != LAT + 3) begin n_fail++; $display("FAIL store_byte_latency: got %0d, required %0d", lat, LAT + 3); end
    if (rd !== 64'd0) begin n_fail++; $display("FAIL store_rdata: got %h, required 0", rd); end
    exp = model_access(1'b0, 2'd3, 64'h0, 64'h0, eerr);
    do_req(1'b0, 2'd3, 64'h0, 64'h0, rd, er, lat, acc);
    n_checks++;
    if (rd !== 64'h1122AB4455667788) begin n_fail++; $display("FAIL store_byte_merge: got %h, required 1122ab4455667788", rd); end
  endtask

  task automatic test_wrap;
    logic [63:0] rd, exp; logic er; bit eerr; int lat, acc;
    logic [63:0] a;
    a = 64'(8 * DEPTH + 2);
    exp = model_access(1'b1, 2'd1, a, 64'hBEEF, eerr);
    do_req(1'b1, 2'd1, a, 64'hBEEF, rd, er, lat, acc);
    exp = model_access(1'b0, 2'd3, 64'h0, 64'h0, eerr);
    do_req(1'b0, 2'd3, 64'h0, 64'h0, rd, er, lat, acc);
    n_checks++;
    if (rd !== 64'h1122AB44BEEF7788 || exp !== 64'h1122AB44BEEF7788) begin
      n_fail++; $display("FAIL wrap_half_store: got %h, required 1122ab44beef7788", rd);
    end
  endtask

  task automatic test_misalign;
    logic [63:0] rd, exp; logic er; bit eerr; int lat, acc;
    exp = model_access(1'b0, 2'd2, 64'h6, 64'h0, eerr);
    do_req(1'b0, 2'd2, 64'h6, 64'h0, rd, er, lat, acc);
    n_checks += 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (er !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %0b, required 1", er); end
    if (rd !== 64'd0) begin n_fail++; $display("FAIL misalign_rdata: got %h, required 0", rd); end
`else
    if (er !== 1'b0) begin n_fail++; $display("FAIL misalign_err: got %0b, required 0", er); end
    if (rd !== 64'h1122AB44 || exp !== 64'h1122AB44) begin n_fail++; $display("FAIL misalign_rdata: got %h, required 1122ab44", rd); end
`endif
    // Misaligned store: under trapping it responds early and leaves memory intact.
    exp = model_access(1'b1, 2'd2, 64'h6, 64'hCAFEF00D, eerr);
    do_req(1'b1, 2'd2, 64'h6, 64'hCAFEF00D, rd, er, lat, acc);
    n_checks += 2;
    if (lat != (eerr ? LAT + 2 : LAT + 3)) begin n_fail++; $display("FAIL misalign_store_latency: got %0d, required %0d", lat, eerr ? LAT + 2 : LAT + 3); end
    if (er !== 1'(eerr)) begin n_fail++; $display("FAIL misalign_store_err: got %0b, required %0b", er, eerr); end
    exp = model_access(1'b0, 2'd3, 64'h0, 64'h0, eerr);
    do_req(1'b0, 2'd3, 64'h0, 64'h0, rd, er, lat, acc);
    n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL misalign_store_effect: got %h, required %h", rd, exp); end
  endtask

  task automatic test_backpressure;
    logic [63:0] exp1, exp2; bit eerr; int n;
    exp1 = model_access(1'b0, 2'd1, 64'h2, 64'h0, eerr);
    exp2 = model_access(1'b0, 2'd3, 64'h0, 64'h0, eerr);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_addr = 64'h2;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin @(posedge clock); #1; n++; end
    // Offer a second request while the first response is stalled.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      n_checks += 3;
      if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %0b, required 1", resp_valid); end
      if (resp_rdata !== exp1) begin n_fail++; $display("FAIL bp_rdata: got %h, required %h", resp_rdata, exp1); end
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready: got %0b, required 0", req_ready); end
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    n_checks += 2;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_handshake_valid: got %0b, required 0", resp_valid); end
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_same_cycle_accept: req_ready=%0b, required 1", req_ready); end
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin @(posedge clock); #1; n++; end
    n_checks += 2;
    if (n + 1 != LAT + 2) begin n_fail++; $display("FAIL bp_second_latency: got %0d, required %0d", n + 1, LAT + 2); end
    if (resp_rdata !== exp2) begin n_fail++; $display("FAIL bp_second_rdata: got %h, required %h", resp_rdata, exp2); end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back;
    logic [63:0] rd; logic er; bit eerr; int lat, a1, a2, a3, a4;
    logic [63:0] exp;
    exp = model_access(1'b0, 2'd2, 64'h4, 64'h0, eerr);
    do_req(1'b0, 2'd2, 64'h4, 64'h0, rd, er, lat, a1);
    do_req(1'b0, 2'd2, 64'h4, 64'h0, rd, er, lat, a2);
    n_checks += 2;
    if (a2 - a1 != LAT + 3) begin n_fail++; $display("FAIL b2b_load_period: got %0d, required %0d", a2 - a1, LAT + 3); end
    if (rd !== exp) begin n_fail++; $display("FAIL b2b_load_rdata: got %h, required %h", rd, exp); end
    exp = model_access(1'b1, 2'd0, 64'h9, 64'h5A, eerr);
    do_req(1'b1, 2'd0, 64'h9, 64'h5A, rd, er, lat, a3);
    exp = model_access(1'b1, 2'd0, 64'hA, 64'hA5, eerr);
    do_req(1'b1, 2'd0, 64'hA, 64'hA5, rd, er, lat, a4);
    n_checks++;
    if (a4 - a3 != LAT + 4) begin n_fail++; $display("FAIL b2b_store_period: got %0d, required %0d", a4 - a3, LAT + 4); end
  endtask

  task automatic test_reset_write;
    logic [63:0] rd, exp; logic er; bit eerr; int lat, acc;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 64'h0; req_wdata = 64'hFF;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (LAT + 1) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_checks += 3;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_valid: got %0b, required 0", resp_valid); end
    if (resp_rdata !== 64'd0) begin n_fail++; $display("FAIL rstw_rdata: got %h, required 0", resp_rdata); end
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstw_req_ready: got %0b, required 1", req_ready); end
    @(posedge clock); #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstw_idle: req_ready=%0b resp_valid=%0b, required 1/0", req_ready, resp_valid);
    end
    exp = model_access(1'b0, 2'd3, 64'h0, 64'h0, eerr);
    do_req(1'b0, 2'd3, 64'h0, 64'h0, rd, er, lat, acc);
    n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL rstw_no_write: got %h, required %h", rd, exp); end
  endtask

  task automatic test_random;
    logic [63:0] rd, exp, a, wd; logic er; bit eerr, we; logic [1:0] sz; int lat, acc;
    // Give every word a known value first.
    for (int w = 1; w < DEPTH; w++) begin
      wd = {$urandom, $urandom};
      exp = model_access(1'b1, 2'd3, 64'(w * 8), wd, eerr);
      do_req(1'b1, 2'd3, 64'(w * 8), wd, rd, er, lat, acc);
    end
    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      wd = {$urandom, $urandom};
      exp = model_access(we, sz, a, wd, eerr);
      do_req(we, sz, a, wd, rd, er, lat, acc);
      n_checks += 3;
      if (rd !== exp) begin n_fail++; $display("FAIL rand_rdata[%0d]: we=%0b sz=%0d addr=%h got %h, required %h", t, we, sz, a, rd, exp); end
      if (er !== 1'(eerr)) begin n_fail++; $display("FAIL rand_err[%0d]: got %0b, required %0b", t, er, eerr); end
      if (lat != ((we && !eerr) ? LAT + 3 : LAT + 2)) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d, required %0d", t, lat, (we && !eerr) ? LAT + 3 : LAT + 2);
      end
    end
  endtask

  initial begin
    for (int w = 0; w < DEPTH; w++) model_mem[w] = 64'd0;
    test_reset;
    test_load_basic;
    test_store_byte;
    test_wrap;
    test_misalign;
    test_backpressure;
    test_back_to_back;
    test_reset_write;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the multicycle RISC-V core's load/store requests over a valid/ready request/response handshake. It holds a 64-bit-wide word array and performs byte/half/word/double accesses with a configurable wait-state latency. Sub-word stores are done as read-modify-write. Loads return the addressed lane right-aligned and zero-extended; the core's load-extension logic applies sign extension. It sits between the core's ALU-output address register and the data path, replacing the fixed-latency data memory.

## Interface
- DEPTH, 256: number of 64-bit words; power of two.
- LATENCY, 2: wait-state cycles inserted before the array access; range 0–15.
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  64  load data, lane-shifted to bit 0 and zero-extended; 0 for stores.
- resp_err  out  1  misaligned access flagged (see Configuration).

## Operation
- States: IDLE, WAIT, ACCESS, WRITE, RESP.
- IDLE: req_ready = 1. On req_valid, latch we/size/addr/wdata. Go to WAIT if LATENCY > 0, otherwise to ACCESS.
- WAIT: count down LATENCY cycles, then go to ACCESS.
- ACCESS: read word index = addr[3 +: log2(DEPTH)] into the old-word register. Upper address bits are ignored, so the index wraps modulo DEPTH.
  - Load, or a flagged-error request: go to RESP.
  - Store: go to WRITE.
- WRITE: merge the req_wdata low lane into the old word at byte offset addr[2:0] with the byte mask for the size, write the array, then go to RESP. Size 3 overwrites all 8 bytes.
- RESP: resp_valid = 1, outputs held stable until resp_ready. Return to IDLE on the handshake cycle. A new request is not accepted in that same cycle.
- Load data: (old_word >> 8·addr[2:0]) masked to 8/16/32/64 bits.
- Reset at any point: state to IDLE, counter to 0, the latched request is dropped, and no array write occurs in that cycle. Array contents are not reset.

## Timing
- Reset values: req_ready = 1 in the first cycle after reset deasserts; resp_valid = 0, resp_rdata = 0, resp_err = 0.
- With the accept edge as cycle 0, resp_valid rises at cycle LATENCY+2 for a load and LATENCY+3 for a store, given resp_ready held high.
- Erroring store: resp_valid at LATENCY+2, no write.
- Throughput: one request per LATENCY+3 (load) or LATENCY+4 (store) cycles.
- resp_rdata and resp_err are registered and stable for the whole time resp_valid is high.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A request with addr not naturally aligned for its size gets resp_err = 1, resp_rdata = 0, and no array write.
  - Misaligned means: half with addr[0] ≠ 0, word with addr[1:0] ≠ 0, double with addr[2:0] ≠ 0.
- Undefined:
  - resp_err is tied to 0.
  - The offset is forced to natural alignment by clearing the low log2(bytes) address bits before use.

## Structure
- Package dmem_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_D).
  - state enum.
  - Byte-mask and width-mask constant functions.
- Sub-module dmem_lane_merge: combinational merge of old word, store data, offset and size into the new word, plus load-lane extraction. Instantiated once.
- The array, FSM and counter live in the top module.

## Test plan
- Load after reset with LATENCY = 2, word 0 preloaded to 0x1122334455667788; load size 0, addr 0x3 → resp_valid at cycle 4, resp_rdata = 0x55.
- Store byte 0xAB at addr 0x5 over word 0x1122334455667788, then load double at 0x0 → 0x1122AB4455667788; store resp_valid at cycle 5.
- Half store of 0xBEEF at addr 8·DEPTH + 2 → lands in word 0, bytes 2–3 (wrap check).
- Misaligned word load at addr 0x6:
  - With DMEM_MISALIGN_TRAP_EN: resp_err = 1, rdata = 0.
  - Without: reads from offset 4, resp_err = 0.
- Backpressure: hold resp_ready low for 5 cycles → resp_valid and resp_rdata stay stable and req_ready stays 0; the next request is accepted only after the handshake.
- Reset asserted during WRITE of a store of 0xFF at addr 0 → word unchanged, outputs at reset values, req_ready = 1 the next cycle.
